// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the two-requester data-memory arbiter.
package dmem_arb_pkg;

  localparam int NUM_REQ = 2;
  localparam int CNT_W   = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

endpackage

// File: rtl/dmem_arb_pick.sv
// Combinational winner selection: one-hot grant from the request vector.
// On a tie the requester that did not win last time (ptr_i) is chosen.
module dmem_arb_pick
  import dmem_arb_pkg::*;
(
  input  logic [NUM_REQ-1:0] req_i,
  input  logic               ptr_i,
  output logic [NUM_REQ-1:0] gnt_o
);

  always_comb begin
    gnt_o = req_i;
    if (&req_i) begin
      gnt_o = ptr_i ? NUM_REQ'(1) : NUM_REQ'(2);
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-requester data-memory arbiter: IDLE -> ACCESS (LAT cycles) -> RESP.
// Define DMEM_ARB_RR_EN for round-robin tie breaking; otherwise requester 0 wins ties.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int LAT    = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              done0,
  output logic              done1,
  output logic [DATA_W-1:0] rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_read,
  output logic              mem_write,
  input  logic [DATA_W-1:0] mem_rdata
);

  state_t              state_q, state_d;
  logic [NUM_REQ-1:0]  owner_q, owner_d;
  logic                we_q, we_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;

  logic [NUM_REQ-1:0]  req_vec;
  logic [NUM_REQ-1:0]  pick;
  logic                ptr;
  logic                grant;

  assign req_vec = {req1, req0};
  assign grant   = (state_q == IDLE) && (|req_vec);

  dmem_arb_pick u_pick (
    .req_i (req_vec),
    .ptr_i (ptr),
    .gnt_o (pick)
  );

`ifdef DMEM_ARB_RR_EN
  logic ptr_q, ptr_d;

  assign ptr_d = grant ? pick[1] : ptr_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) ptr_q <= 1'b0;
    else     ptr_q <= ptr_d;
  end

  assign ptr = ptr_q;
`else
  // Pretending requester 1 always won last makes requester 0 win every tie.
  assign ptr = 1'b1;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      owner_q <= '0;
      we_q    <= 1'b0;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      we_q    <= we_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    we_d    = we_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    unique case (state_q)
      IDLE: begin
        if (grant) begin
          owner_d = pick;
          we_d    = pick[1] ? we1    : we0;
          addr_d  = pick[1] ? addr1  : addr0;
          wdata_d = pick[1] ? wdata1 : wdata0;
          cnt_d   = CNT_W'(LAT - 1);
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        if (cnt_q == '0) begin
          if (!we_q) rdata_d = mem_rdata;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // The memory address/data registers double as the latched payload, so they
  // naturally hold their last value once the access is over.
  assign gnt0      = (state_q != IDLE) && owner_q[0];
  assign gnt1      = (state_q != IDLE) && owner_q[1];
  assign done0     = (state_q == RESP) && owner_q[0];
  assign done1     = (state_q == RESP) && owner_q[1];
  assign mem_read  = (state_q == ACCESS) && !we_q;
  assign mem_write = (state_q == ACCESS) && we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign rdata     = rdata_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed scenarios plus random traffic
// checked every cycle against a timestamp-based transaction model.
module tb_dmem_arbiter;

  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int LAT = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          req0, req1, we0, we1;
  logic [AW-1:0] addr0, addr1;
  logic [DW-1:0] wdata0, wdata1;
  logic          gnt0, gnt1, done0, done1;
  logic [DW-1:0] rdata;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_read, mem_write;
  logic [DW-1:0] mem_rdata;

  always #5 clk = ~clk;

  dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .LAT(LAT)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
    .rdata(rdata), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_read(mem_read), .mem_write(mem_write), .mem_rdata(mem_rdata)
  );

  // Environment memory, driven only by the DUT strobes.
  logic [DW-1:0] env_mem [16];
  assign mem_rdata = env_mem[mem_addr[3:0]];

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Requesters
  bit            r_pend  [2];
  bit            r_drop  [2];
  bit            r_we    [2];
  logic [3:0]    r_addr  [2];
  logic [DW-1:0] r_wdata [2];
  int            new_pct = 0;
  bit            drop_en = 0;

  // Transaction model: one access at a time, timed from the edge it was granted.
  int            cyc = 0;
  bit            m_busy;
  int            m_owner, m_start, m_ptr;
  bit            m_we;
  logic [3:0]    m_addr;
  logic [DW-1:0] m_wdata, m_rdata, m_mwdata;
  logic [AW-1:0] m_maddr;
  logic [DW-1:0] ref_mem [16];

  function automatic int winner(input bit r0, input bit r1);
    if (r0 && r1) begin
`ifdef DMEM_ARB_RR_EN
      return (m_ptr == 0) ? 1 : 0;
`else
      return 0;
`endif
    end
    return r1 ? 1 : 0;
  endfunction

  task automatic model_reset();
    m_busy = 0; m_ptr = 0; m_owner = 0; m_start = 0; m_we = 0;
    m_rdata = '0; m_maddr = '0; m_mwdata = '0;
  endtask

  task automatic model_edge();
    int w;
    cyc++;
    if (m_busy) begin
      if (cyc == m_start + 1 && m_we) ref_mem[m_addr] = m_wdata;
      if (cyc == m_start + LAT && !m_we) m_rdata = ref_mem[m_addr];
      if (cyc == m_start + LAT + 1) m_busy = 0;
    end else if (req0 || req1) begin
      w = winner(req0, req1);
      m_busy = 1; m_owner = w; m_start = cyc; m_ptr = w;
      m_we = r_we[w]; m_addr = r_addr[w]; m_wdata = r_wdata[w];
      m_maddr = {28'd0, r_addr[w]}; m_mwdata = r_wdata[w];
    end
  endtask

  function automatic bit in_access();
    return m_busy && (cyc - m_start) < LAT;
  endfunction

  function automatic bit in_resp();
    return m_busy && (cyc - m_start) == LAT;
  endfunction

  task automatic compare_outputs();
    bit acc, rsp;
    acc = in_access();
    rsp = in_resp();
    chk_eq("gnt0", gnt0, (acc || rsp) && m_owner == 0);
    chk_eq("gnt1", gnt1, (acc || rsp) && m_owner == 1);
    chk_eq("done0", done0, rsp && m_owner == 0);
    chk_eq("done1", done1, rsp && m_owner == 1);
    chk_eq("mem_read", mem_read, acc && !m_we);
    chk_eq("mem_write", mem_write, acc && m_we);
    chk_eq("mem_addr", mem_addr, m_maddr);
    chk_eq("mem_wdata", mem_wdata, m_mwdata);
    chk_eq("rdata", rdata, m_rdata);
    chk_eq("gnt_onehot", gnt0 & gnt1, 1'b0);
  endtask

  task automatic update_requesters();
    for (int r = 0; r < 2; r++) begin
      if (in_resp() && m_owner == r) begin
        $display("txn req%0d %s addr=%0h wdata=%0h rdata=%0h", r, m_we ? "WR" : "RD",
                 m_addr, m_wdata, m_rdata);
        r_pend[r] = 0;
        r_drop[r] = 0;
      end
      if (r_pend[r] && !r_drop[r] && drop_en && in_access() && m_owner == r &&
          $urandom_range(9) == 0)
        r_drop[r] = 1;
      if (!r_pend[r] && $urandom_range(99) < new_pct) begin
        r_pend[r]  = 1;
        r_we[r]    = $urandom_range(1) == 1;
        r_addr[r]  = 4'($urandom_range(15));
        r_wdata[r] = $urandom;
      end
    end
  endtask

  task automatic apply_inputs();
    req0 = r_pend[0] && !r_drop[0]; we0 = r_we[0];
    addr0 = {28'd0, r_addr[0]};     wdata0 = r_wdata[0];
    req1 = r_pend[1] && !r_drop[1]; we1 = r_we[1];
    addr1 = {28'd0, r_addr[1]};     wdata1 = r_wdata[1];
  endtask

  task automatic step();
    logic          wr;
    logic [3:0]    wa;
    logic [DW-1:0] wd;
    wr = mem_write; wa = mem_addr[3:0]; wd = mem_wdata;
    @(posedge clk);
    if (wr && !rst) env_mem[wa] = wd;
    if (!rst) model_edge();
    #1;
    compare_outputs();
    update_requesters();
    apply_inputs();
  endtask

  task automatic drain(input string tag);
    int k;
    new_pct = 0;
    k = 0;
    while ((r_pend[0] || r_pend[1]) && k < 100) begin
      step();
      k++;
    end
    chk_eq(tag, r_pend[0] || r_pend[1], 1'b0);
    step();
    step();
  endtask

  always @(posedge clk) begin
    assert (!(gnt0 && gnt1)) else $error("gnt not one-hot");
  end

  int         grants [$];
  bit         prev_g;
  int         lat, nstrobe;
  logic [DW-1:0] rd_before;
  bit         seen;
  int         exp_seq [4];

  initial begin
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      r_pend[i] = 0; r_drop[i] = 0; r_we[i] = 0; r_addr[i] = '0; r_wdata[i] = '0;
    end
    for (int i = 0; i < 16; i++) begin
      env_mem[i] = $urandom;
      ref_mem[i] = env_mem[i];
    end
    model_reset();
    apply_inputs();
    repeat (2) step();
    rst = 1'b0;

    // Both requesters held together: grants follow the tie-break rule.
`ifdef DMEM_ARB_RR_EN
    exp_seq = '{1, 0, 1, 0};
`else
    exp_seq = '{0, 0, 0, 0};
`endif
    new_pct = 100;
    for (int r = 0; r < 2; r++) begin
      r_pend[r] = 1; r_we[r] = 0; r_addr[r] = 4'(r + 1); r_wdata[r] = '0;
    end
    apply_inputs();
    prev_g = 0;
    for (int k = 0; k < 60 && grants.size() < 4; k++) begin
      step();
      if ((gnt0 || gnt1) && !prev_g) grants.push_back(gnt1 ? 1 : 0);
      prev_g = gnt0 || gnt1;
    end
    chk_eq("tie_grant_count", grants.size(), 4);
    for (int i = 0; i < 4 && i < grants.size(); i++)
      chk_eq($sformatf("tie_grant%0d", i), grants[i], exp_seq[i]);
    drain("drain_tie");

    // Read from requester 0, address 4 holding 0xA.
    env_mem[4] = 32'hA; ref_mem[4] = 32'hA;
    r_pend[0] = 1; r_we[0] = 0; r_addr[0] = 4'd4; r_wdata[0] = '0;
    apply_inputs();
    lat = 0; nstrobe = 0;
    for (int k = 1; k <= 20 && lat == 0; k++) begin
      step();
      if (mem_read) nstrobe++;
      if (done0) begin
        lat = k;
        chk_eq("read_rdata", rdata, 32'hA);
      end
    end
    // Counting the request-sampling edge as edge 1.
    chk_eq("read_latency", lat, LAT + 1);
    chk_eq("read_strobes", nstrobe, LAT);
    drain("drain_read");

    // Write from requester 1: address 8, data 0x55; rdata must not move.
    rd_before = rdata;
    r_pend[1] = 1; r_we[1] = 1; r_addr[1] = 4'd8; r_wdata[1] = 32'h55;
    apply_inputs();
    lat = 0; nstrobe = 0;
    for (int k = 1; k <= 20 && lat == 0; k++) begin
      step();
      if (mem_write) begin
        nstrobe++;
        chk_eq("write_addr", mem_addr, 32'd8);
        chk_eq("write_data", mem_wdata, 32'h55);
      end
      if (done1) begin
        lat = k;
        chk_eq("write_rdata_held", rdata, rd_before);
      end
    end
    chk_eq("write_latency", lat, LAT + 1);
    chk_eq("write_strobes", nstrobe, LAT);
    drain("drain_write");
    chk_eq("write_mem", env_mem[8], 32'h55);

    // Reset in the second ACCESS cycle aborts the access; the request is re-served.
    r_pend[0] = 1; r_we[0] = 0; r_addr[0] = 4'd5; r_wdata[0] = '0;
    apply_inputs();
    step();
    step();
    chk_eq("abort_pre_read", mem_read, 1'b1);
    #2 rst = 1'b1;
    #1;
    chk_eq("abort_read", mem_read, 1'b0);
    chk_eq("abort_write", mem_write, 1'b0);
    chk_eq("abort_gnt0", gnt0, 1'b0);
    chk_eq("abort_done0", done0, 1'b0);
    model_reset();
    r_drop[0] = 0;
    step();
    step();
    rst = 1'b0;
    seen = 0;
    for (int k = 0; k < 20 && !seen; k++) begin
      step();
      if (gnt0) seen = 1;
    end
    chk_eq("regrant_after_reset", seen, 1'b1);
    drain("drain_reset");

    // Random traffic with occasional mid-access request drops.
    new_pct = 25;
    drop_en = 1;
    repeat (1500) step();
    drop_en = 0;
    drain("drain_random");

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, address width for both requesters and the memory side.
REQ-002 SHALL have parameter DATA_W, default 32, data width.
REQ-003 SHALL have parameter LAT, default 1, memory access cycles (1..15) that the mem_* strobes stay asserted.
REQ-004 SHALL have port clk, input, 1, single clock; all state changes on the rising edge.
REQ-005 SHALL have port rst, input, 1, asynchronous, active-high reset.
REQ-006 SHALL have ports req0/req1, input, 1, access request from requester 0 or 1.
REQ-007 SHALL have ports we0/we1, input, 1, request type: 1 = write, 0 = read.
REQ-008 SHALL have ports addr0/addr1, input, ADDR_W, word address.
REQ-009 SHALL have ports wdata0/wdata1, input, DATA_W, write data.
REQ-010 SHALL have ports gnt0/gnt1, output, 1, the requester owns the memory (ACCESS or RESP state).
REQ-011 SHALL have ports done0/done1, output, 1, one-cycle completion pulse.
REQ-012 SHALL have port rdata, output, DATA_W, read result; valid only while a done pulse is high.
REQ-013 SHALL have ports mem_addr (ADDR_W), mem_wdata (DATA_W), mem_read (1), mem_write (1), output, memory-side command.
REQ-014 SHALL have port mem_rdata, input, DATA_W, memory read data.

Function
REQ-015 SHALL implement three states: IDLE, ACCESS and RESP.
REQ-016 IDLE: on any req high, SHALL latch the winner's id, we, addr and wdata, load the cycle counter with LAT-1, and go to ACCESS next cycle.
REQ-017 ACCESS: SHALL drive mem_addr and mem_wdata from the latched values and assert mem_read=!we or mem_write=we.
  - Counter decrements each cycle.
  - At counter 0, SHALL capture mem_rdata into rdata (reads only) and go to RESP.
REQ-018 RESP: SHALL deassert mem strobes, pulse done of the owner for exactly one cycle, and return to IDLE.
REQ-019 Total latency from the request-sampled IDLE edge to the done pulse SHALL be LAT+1 cycles.
  - There is one idle cycle between back-to-back grants.
REQ-020 gnt SHALL be one-hot or zero, and SHALL never change in ACCESS or RESP.
REQ-021 Requesters SHALL hold req and payload until done.
  - Deassertion of req during ACCESS SHALL be ignored; the access completes.
REQ-022 Simultaneous req0 and req1 in IDLE SHALL be resolved per REQ-030/031; the loser stays pending and is served next.
REQ-023 Write accesses SHALL leave rdata unchanged.
REQ-024 Outside ACCESS, mem_read=mem_write=0, and mem_addr/mem_wdata SHALL hold their last values.

Reset
REQ-025 While rst is high, SHALL force: state IDLE, gnt0=gnt1=0, done0=done1=0, mem_read=mem_write=0, mem_addr=0, mem_wdata=0, rdata=0, counter=0, round-robin pointer=0.
REQ-026 Reset asserted mid-ACCESS SHALL abort the access immediately, asynchronously deassert the strobes, and produce no done pulse.
REQ-027 After rst falls, the first arbitration SHALL occur on the first rising edge with a req high.

Configuration
REQ-028 SHALL provide macro DMEM_ARB_RR_EN.
REQ-029 Round-robin pointer rules:
  - Pointer records the last winner.
  - On a tie, the requester not equal to the pointer wins.
  - Pointer updates on each grant.
REQ-030 With DMEM_ARB_RR_EN defined: round-robin per REQ-029.
REQ-031 Without DMEM_ARB_RR_EN: fixed priority, requester 0 always wins ties, and no pointer register exists.

Structure
REQ-032 Package dmem_arb_pkg SHALL hold:
  - the state enum (IDLE, ACCESS, RESP);
  - constant NUM_REQ=2;
  - the counter width localparam CNT_W=4.
REQ-033 Winner selection SHALL be in sub-module dmem_arb_pick (combinational, req vector plus pointer in, one-hot out); the FSM stays in dmem_arbiter.

Verification
REQ-034 LAT=1: req0 read addr=4 with memory[4]=0xA → mem_read one cycle, done0 pulse with rdata=0xA two cycles after sampling.
REQ-035 req1 write addr=8, wdata=0x55 → mem_write high for LAT cycles with mem_addr=8 and mem_wdata=0x55; done1 pulses; rdata unchanged.
REQ-036 req0 and req1 held together for 4 transactions: grants alternate 1,0,1,0 with RR_EN, and 0,0,0,0 without it.
REQ-037 LAT=3, rst pulsed in the 2nd ACCESS cycle → strobes low at once, no done, IDLE after release, pending req re-granted.
REQ-038 req0 dropped during ACCESS → access still completes and done0 pulses; gnt never one-hot-violated throughout (assertion).
